apb_master_bridge: RTL
======================

# apb_master_bridge

Upstream APB requester that converts a simple valid/ready command interface into APB3 transfers for the APB slave on the same bus. It owns the PSELx/PENABLE sequencing, holds address/control/data stable across SETUP and ACCESS, absorbs slave wait states, and returns read data plus error status as a one-cycle response pulse. A programmable wait-state timeout aborts transfers to a slave that never asserts PREADY.

## Interface
- DW, 32, data width (PWDATA, PRDATA, cmd_wdata, rsp_rdata)
- AW, 32, address width (PADDR, cmd_addr)
- TIMEOUT, 16, max consecutive ACCESS cycles with PREADY=0 before abort; 0 disables timeout

- PCLK  in  1  bus clock; all logic on rising edge
- PRESETn  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at rising PCLK
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  AW  transfer address
- cmd_wdata  in  DW  write data (ignored for reads)
- rsp_valid  out  1  one-cycle response pulse; no backpressure
- rsp_rdata  out  DW  read data (0 for writes and timeouts)
- rsp_err  out  1  PSLVERR at completion, or timeout
- rsp_timeout  out  1  transfer aborted by timeout
- PADDR  out  AW  APB address
- PSELx  out  1  APB select
- PENABLE  out  1  APB enable
- PWRITE  out  1  APB direction
- PWDATA  out  DW  APB write data
- PREADY  in  1  slave ready / wait-state control
- PSLVERR  in  1  slave error, valid only with PREADY=1 in ACCESS
- PRDATA  in  DW  slave read data, valid only with PREADY=1 in ACCESS

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- IDLE: PSELx=0, PENABLE=0; cmd_ready=1. On accept: register cmd_addr/cmd_write/cmd_wdata into PADDR/PWRITE/PWDATA; next = SETUP.
- SETUP: PSELx=1, PENABLE=0; cmd_ready=0; next = ACCESS unconditionally.
- ACCESS: PSELx=1, PENABLE=1; PADDR/PWRITE/PWDATA held.
  - PREADY=0: stay; wait counter increments.
  - PREADY=1: completion. Capture PRDATA (reads only; writes return 0) and PSLVERR. cmd_ready=PREADY combinationally in this state; if cmd_valid, load new command, next = SETUP (PSELx stays 1, PENABLE drops); else next = IDLE.
- Timeout (TIMEOUT>0): counter counts ACCESS cycles sampled with PREADY=0; on the edge where it reaches TIMEOUT, abort: next = IDLE, rsp_err=1, rsp_timeout=1, rsp_rdata=0. No command accepted on the abort edge (cmd_ready=0). Counter clears on entering SETUP. Counter width max(1,$clog2(TIMEOUT+1)).
- PREADY/PSLVERR/PRDATA ignored outside ACCESS.
- PADDR/PWRITE/PWDATA retain last values in IDLE.

## Timing
- Reset values: cmd_ready=0 during reset then 1 in IDLE; PSELx=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0; FSM=IDLE; counter=0.
- Accept at edge N → SETUP during cycle N..N+1 → ACCESS from edge N+1 → earliest completion at edge N+2 (PREADY=1 sampled).
- rsp_valid=1 for exactly one cycle after completion/abort edge; rsp_rdata/rsp_err/rsp_timeout valid with it and held until next response.
- Zero-wait transfer: 2 PCLK; each wait state adds 1. Back-to-back zero-wait: one transfer per 2 PCLK, no IDLE gap, PSELx continuously 1.
- Reset asserted mid-transfer: all outputs return to reset values immediately (asynchronous); in-flight transfer dropped, no rsp_valid.
- Simultaneous completion and new command: response for old transfer and SETUP for new one occur in the same cycle.

## Test plan
- Reset then write addr=0x0, wdata=10, PREADY=1 → SETUP 1 cycle, ACCESS 1 cycle, PWDATA=10 held both; rsp_valid pulse, rsp_err=0, rsp_rdata=0.
- Read addr=0x8 with 2 wait states, PRDATA=0xA5A5_0001 at PREADY → ACCESS lasts 3 cycles, PADDR=8 stable; rsp_rdata=0xA5A5_0001.
- Read addr=0x0 with PSLVERR=1 at completion → rsp_err=1, rsp_timeout=0; PSLVERR asserted while PREADY=0 is ignored.
- Two back-to-back writes (0x4→1, 0xC→2), cmd_valid held → PSELx never drops, PENABLE 1-0-1 pattern, two rsp_valid pulses 2 cycles apart.
- TIMEOUT=16, PREADY held 0 → abort after 16 ACCESS cycles: PSELx=0, rsp_err=1, rsp_timeout=1, rsp_rdata=0; next command accepted normally.
- PRESETn pulsed low during ACCESS → PSELx/PENABLE drop without clock, no rsp_valid, FSM IDLE after release.

Source files
------------

// File: rtl/apb_master_bridge_if.sv
// Command/response and APB3 bus signals of the APB master bridge.
// The master modport is the bridge's view; the slave modport is the environment's view.
interface apb_master_bridge_if #(
  parameter int DW = 32,
  parameter int AW = 32
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          rsp_timeout;
  logic [AW-1:0] PADDR;
  logic          PSELx;
  logic          PENABLE;
  logic          PWRITE;
  logic [DW-1:0] PWDATA;
  logic          PREADY;
  logic          PSLVERR;
  logic [DW-1:0] PRDATA;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, PREADY, PSLVERR, PRDATA,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           PADDR, PSELx, PENABLE, PWRITE, PWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, PREADY, PSLVERR, PRDATA,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           PADDR, PSELx, PENABLE, PWRITE, PWDATA
  );
endinterface

// File: rtl/apb_master_bridge.sv
// APB3 requester: turns valid/ready commands into SETUP/ACCESS transfers and returns
// a one-cycle response pulse; a wait-state timeout aborts transfers that never complete.
module apb_master_bridge #(
  parameter int DW      = 32,
  parameter int AW      = 32,
  parameter int TIMEOUT = 16
) (
  input logic                 PCLK,
  input logic                 PRESETn,
  apb_master_bridge_if.master bus
);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  state_e        state_q;
  logic [CW-1:0] wait_cnt_q;
  logic          psel_q;
  logic          penable_q;
  logic          pwrite_q;
  logic [AW-1:0] paddr_q;
  logic [DW-1:0] pwdata_q;
  logic          rsp_valid_q;
  logic [DW-1:0] rsp_rdata_q;
  logic          rsp_err_q;
  logic          rsp_timeout_q;

  logic complete_s;
  logic abort_s;
  logic cmd_ready_s;
  logic accept_s;

  // Completion, timeout abort and command acceptance for the current cycle
  always_comb begin
    complete_s  = (state_q == ACCESS) && bus.PREADY;
    abort_s     = (TIMEOUT > 0) && (state_q == ACCESS) && !bus.PREADY &&
                  (wait_cnt_q == CNT_LAST);
    // ready is forced low while reset is held, not just after release
    cmd_ready_s = PRESETn && ((state_q == IDLE) || complete_s);
    accept_s    = bus.cmd_valid && cmd_ready_s;
  end

  // Transfer sequencing FSM with registered bus and response outputs
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q       <= IDLE;
      wait_cnt_q    <= '0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept_s) begin
            paddr_q    <= bus.cmd_addr;
            pwrite_q   <= bus.cmd_write;
            pwdata_q   <= bus.cmd_wdata;
            psel_q     <= 1'b1;
            penable_q  <= 1'b0;
            wait_cnt_q <= '0;
            state_q    <= SETUP;
          end else begin
            state_q <= IDLE;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          if (complete_s) begin
            rsp_valid_q   <= 1'b1;
            rsp_rdata_q   <= pwrite_q ? '0 : bus.PRDATA;
            rsp_err_q     <= bus.PSLVERR;
            rsp_timeout_q <= 1'b0;
            penable_q     <= 1'b0;
            if (accept_s) begin
              // back-to-back: PSELx stays high straight into the next SETUP
              paddr_q    <= bus.cmd_addr;
              pwrite_q   <= bus.cmd_write;
              pwdata_q   <= bus.cmd_wdata;
              wait_cnt_q <= '0;
              state_q    <= SETUP;
            end else begin
              psel_q  <= 1'b0;
              state_q <= IDLE;
            end
          end else if (abort_s) begin
            rsp_valid_q   <= 1'b1;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b1;
            rsp_timeout_q <= 1'b1;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            wait_cnt_q    <= '0;
            state_q       <= IDLE;
          end else begin
            wait_cnt_q <= wait_cnt_q + CW'(1);
          end
        end
        default: begin
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready   = cmd_ready_s;
  assign bus.PSELx       = psel_q;
  assign bus.PENABLE     = penable_q;
  assign bus.PWRITE      = pwrite_q;
  assign bus.PADDR       = paddr_q;
  assign bus.PWDATA      = pwdata_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_timeout_q;
endmodule
